// File: rtl/nf_dm_bridge.sv
// nf_dm_bridge
//   Bridges a load/store unit data-memory request port to a single-port,
//   word-organised synchronous RAM with byte write strobes.
//
//   Parameters
//     WAIT_CYCLES  wait states (0..15) inserted before each RAM access
//
//   Ports
//     clk, reset            clock (rising edge), asynchronous active-high reset
//     addr_dm, wd_dm        byte address and right-aligned store data
//     we_dm, size_dm        store/load select, access size (00 B, 01 H, 1x W)
//     req_dm                request, held high until req_ack_dm
//     rd_dm                 right-aligned, zero-filled load data
//     req_ack_dm, misalign  one-cycle acknowledge, misaligned-access flag
//     ram_addr, ram_wd      RAM word address, lane-replicated store data
//     ram_we, ram_en        RAM byte write strobes, access enable
//     ram_rd                RAM read data (one cycle after a read enable)
module nf_dm_bridge #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_dm,
  input  logic [31:0] wd_dm,
  input  logic        we_dm,
  input  logic [1:0]  size_dm,
  input  logic        req_dm,
  output logic [31:0] rd_dm,
  output logic        req_ack_dm,
  output logic        misalign,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wd,
  output logic [3:0]  ram_we,
  output logic        ram_en,
  input  logic [31:0] ram_rd
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DATA,
    ST_ACK
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        mis_q, mis_d;
  logic [31:0] rd_q, rd_d;

  logic        req_mis;
  logic [3:0]  strobe;
  logic [31:0] rd_byte_sh;
  logic [31:0] rd_half_sh;
  logic [31:0] rd_fmt;

  // Alignment of the incoming request; bytes can never be misaligned.
  always_comb begin
    req_mis = 1'b0;
    unique case (size_dm)
      2'b00:   req_mis = 1'b0;
      2'b01:   req_mis = addr_dm[0];
      default: req_mis = |addr_dm[1:0];
    endcase
  end

  // Byte-lane strobes for the captured store.
  always_comb begin
    strobe = 4'b0000;
    unique case (size_q)
      2'b00:   strobe = 4'b0001 << addr_q[1:0];
      2'b01:   strobe = addr_q[1] ? 4'b1100 : 4'b0011;
      default: strobe = 4'b1111;
    endcase
  end

  // Lane replication lets the RAM pick the right bytes with strobes alone.
  always_comb begin
    ram_wd = wd_q;
    unique case (size_q)
      2'b00:   ram_wd = {4{wd_q[7:0]}};
      2'b01:   ram_wd = {2{wd_q[15:0]}};
      default: ram_wd = wd_q;
    endcase
  end

  // Right-align and zero-extend the addressed lanes of the RAM word.
  always_comb begin
    rd_byte_sh = ram_rd >> {addr_q[1:0], 3'b000};
    rd_half_sh = ram_rd >> {addr_q[1], 4'b0000};
    rd_fmt     = ram_rd;
    unique case (size_q)
      2'b00:   rd_fmt = {24'h000000, rd_byte_sh[7:0]};
      2'b01:   rd_fmt = {16'h0000, rd_half_sh[15:0]};
      default: rd_fmt = ram_rd;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    we_d    = we_q;
    size_d  = size_q;
    mis_d   = mis_q;
    rd_d    = rd_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_dm) begin
          addr_d = addr_dm;
          wd_d   = wd_dm;
          we_d   = we_dm;
          size_d = size_dm;
          mis_d  = req_mis;
          if (req_mis) begin
            rd_d    = '0;
            state_d = ST_ACK;
          end else if (WAIT_CYCLES != 0) begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = we_q ? ST_ACK : ST_DATA;
      end
      ST_DATA: begin
        rd_d    = rd_fmt;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      mis_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      size_q  <= size_d;
      mis_q   <= mis_d;
      rd_q    <= rd_d;
    end
  end

  assign ram_en     = (state_q == ST_ACCESS);
  assign ram_we     = (ram_en && we_q) ? strobe : 4'b0000;
  assign ram_addr   = addr_q[31:2];
  assign req_ack_dm = (state_q == ST_ACK);
  assign misalign   = req_ack_dm && mis_q;
  assign rd_dm      = rd_q;

endmodule
